// File: rtl/ps2_kbd_cmd_ctrl.sv
// Host-side PS/2 keyboard command sequencer: runs reset (0xFF + BAT) and LED (0xED + mask)
// sequences through the transmitter, consuming responses and forwarding all other rx bytes.
module ps2_kbd_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 2000000,
   parameter int unsigned BAT_CYCLES     = 75000000,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       kbd_reset_req_i,
   input  logic       led_update_i,
   input  logic [2:0] led_state_i,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   input  logic [7:0] rx_byte_i,
   input  logic       rx_valid_i,
   output logic [7:0] fwd_byte_o,
   output logic       fwd_valid_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       error_o,
   output logic [2:0] leds_applied_o
);

   localparam int unsigned TMAX = (BAT_CYCLES > TIMEOUT_CYCLES) ? BAT_CYCLES : TIMEOUT_CYCLES;
   localparam int TW = $clog2(TMAX + 1);
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   typedef enum logic [2:0] {
      IDLE, SEND_CMD, WAIT_ACK_CMD, SEND_ARG, WAIT_ACK_ARG, SEND_RST, WAIT_ACK_RST, WAIT_BAT
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [RW-1:0] retry_q, retry_d;
   logic          rst_pend_q, rst_pend_d, led_pend_q, led_pend_d;
   logic [2:0]    led_shadow_q, led_shadow_d, led_arg_q, led_arg_d;
   logic [2:0]    leds_applied_q, leds_applied_d;
   logic          done_q, done_d, error_q, error_d;
   logic [7:0]    fwd_byte_q, fwd_byte_d;
   logic          fwd_valid_q, fwd_valid_d;
   logic          consume, rx_ack, rx_nak, ack_to, bat_to;

   assign rx_ack = rx_valid_i && (rx_byte_i == 8'hFA);
   assign rx_nak = rx_valid_i && (rx_byte_i == 8'hFE);
   assign ack_to = (32'(timer_q) + 32'd1) >= TIMEOUT_CYCLES;
   assign bat_to = (32'(timer_q) + 32'd1) >= BAT_CYCLES;

   always_comb begin
      state_d        = state_q;
      timer_d        = timer_q;
      retry_d        = retry_q;
      led_arg_d      = led_arg_q;
      leds_applied_d = leds_applied_q;
      error_d        = error_q;
      done_d         = 1'b0;
      tx_valid_o     = 1'b0;
      tx_data_o      = 8'h00;
      consume        = 1'b0;
      rst_pend_d     = rst_pend_q | kbd_reset_req_i;
      led_pend_d     = led_pend_q | led_update_i;
      led_shadow_d   = led_update_i ? led_state_i : led_shadow_q;
      case (state_q)
         IDLE: begin
            // A request arriving in the start cycle stays pending for a later run.
            if (rst_pend_q) begin
               state_d    = SEND_RST;
               rst_pend_d = kbd_reset_req_i;
               error_d    = 1'b0;
               retry_d    = '0;
            end else if (led_pend_q) begin
               state_d    = SEND_CMD;
               led_pend_d = led_update_i;
               led_arg_d  = led_shadow_q;
               error_d    = 1'b0;
               retry_d    = '0;
            end
         end
         SEND_CMD, SEND_ARG, SEND_RST: begin
            tx_valid_o = 1'b1;
            tx_data_o  = (state_q == SEND_CMD) ? 8'hED :
                         (state_q == SEND_ARG) ? {5'b0, led_arg_q} : 8'hFF;
            if (tx_ready_i) begin
               timer_d = '0;
               state_d = (state_q == SEND_CMD) ? WAIT_ACK_CMD :
                         (state_q == SEND_ARG) ? WAIT_ACK_ARG : WAIT_ACK_RST;
            end
         end
         WAIT_ACK_CMD, WAIT_ACK_ARG, WAIT_ACK_RST: begin
            timer_d = timer_q + TW'(1);
            if (rx_ack) begin
               consume = 1'b1;
               if (state_q == WAIT_ACK_CMD) begin
                  state_d = SEND_ARG;
                  retry_d = '0;
               end else if (state_q == WAIT_ACK_ARG) begin
                  leds_applied_d = led_arg_q;
                  done_d         = 1'b1;
                  state_d        = IDLE;
               end else begin
                  state_d = WAIT_BAT;
                  timer_d = '0;
               end
            end else if (rx_nak || ack_to) begin
               consume = rx_nak;
               if (32'(retry_q) < MAX_RETRIES) begin
                  retry_d = retry_q + RW'(1);
                  state_d = (state_q == WAIT_ACK_CMD) ? SEND_CMD :
                            (state_q == WAIT_ACK_ARG) ? SEND_ARG : SEND_RST;
               end else begin
                  error_d = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         WAIT_BAT: begin
            timer_d = timer_q + TW'(1);
            if (rx_valid_i && rx_byte_i == 8'hAA) begin
               consume        = 1'b1;
               done_d         = 1'b1;
               leds_applied_d = 3'b000;
               state_d        = IDLE;
            end else if (rx_valid_i && rx_byte_i == 8'hFC) begin
               consume = 1'b1;
               error_d = 1'b1;
               state_d = IDLE;
            end else if (bat_to) begin
               error_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      fwd_valid_d = rx_valid_i && !consume;
      fwd_byte_d  = fwd_valid_d ? rx_byte_i : fwd_byte_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q        <= IDLE;
         timer_q        <= '0;
         retry_q        <= '0;
         rst_pend_q     <= 1'b0;
         led_pend_q     <= 1'b0;
         led_shadow_q   <= 3'b000;
         led_arg_q      <= 3'b000;
         leds_applied_q <= 3'b000;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         fwd_byte_q     <= 8'h00;
         fwd_valid_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         timer_q        <= timer_d;
         retry_q        <= retry_d;
         rst_pend_q     <= rst_pend_d;
         led_pend_q     <= led_pend_d;
         led_shadow_q   <= led_shadow_d;
         led_arg_q      <= led_arg_d;
         leds_applied_q <= leds_applied_d;
         done_q         <= done_d;
         error_q        <= error_d;
         fwd_byte_q     <= fwd_byte_d;
         fwd_valid_q    <= fwd_valid_d;
      end
   end

   assign busy_o         = (state_q != IDLE);
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign leds_applied_o = leds_applied_q;
   assign fwd_byte_o     = fwd_byte_q;
   assign fwd_valid_o    = fwd_valid_q;

endmodule

// File: tb/tb_ps2_kbd_cmd_ctrl.sv
// Directed bench for ps2_kbd_cmd_ctrl: LED/reset sequences, resend, retry exhaustion,
// pass-through, request priority and async reset.
module tb_ps2_kbd_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       kbd_reset_req = 1'b0, led_update = 1'b0;
   logic [2:0] led_state = 3'b000;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b1;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_valid = 1'b0;
   logic [7:0] fwd_byte;
   logic       fwd_valid, busy, done, error;
   logic [2:0] leds_applied;

   int n_chk = 0, n_fail = 0;
   logic [7:0] tx_log[$];
   int done_cnt = 0, fwd_cnt = 0, fwd_dbl = 0, busy_rise = 0;
   logic fwd_prev = 1'b0, busy_prev = 1'b0;
   int t0, d0, f0, b0;

   ps2_kbd_cmd_ctrl #(.TIMEOUT_CYCLES(100), .BAT_CYCLES(300), .MAX_RETRIES(3)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .kbd_reset_req_i(kbd_reset_req),
      .led_update_i(led_update), .led_state_i(led_state),
      .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
      .rx_byte_i(rx_byte), .rx_valid_i(rx_valid),
      .fwd_byte_o(fwd_byte), .fwd_valid_o(fwd_valid),
      .busy_o(busy), .done_o(done), .error_o(error), .leds_applied_o(leds_applied));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (tx_valid && tx_ready) tx_log.push_back(tx_data);
         if (done) done_cnt++;
         if (fwd_valid) begin
            fwd_cnt++;
            if (fwd_prev) fwd_dbl++;
         end
         if (busy && !busy_prev) busy_rise++;
      end
      fwd_prev = fwd_valid;
      busy_prev = busy;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic mark();
      t0 = tx_log.size(); d0 = done_cnt; f0 = fwd_cnt; b0 = busy_rise;
   endtask

   task automatic pulse_led(input logic [2:0] m);
      @(posedge clk); #1 led_state = m; led_update = 1'b1;
      @(posedge clk); #1 led_update = 1'b0;
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1 kbd_reset_req = 1'b1;
      @(posedge clk); #1 kbd_reset_req = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      @(posedge clk); #1 rx_byte = b; rx_valid = 1'b1;
      @(posedge clk); #1 rx_valid = 1'b0;
   endtask

   task automatic wait_tx(input int n, input logic [7:0] exp, input string tag);
      int k = 0;
      while (tx_log.size() - t0 < n && k < 2000) begin @(negedge clk); k++; end
      chk({tag, "_cnt"}, tx_log.size() - t0, n);
      if (tx_log.size() - t0 >= n) chk(tag, tx_log[t0 + n - 1], exp);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (!busy && k < 20) begin @(negedge clk); k++; end
      k = 0;
      while (busy && k < 3000) begin @(negedge clk); k++; end
      chk(tag, busy, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      #2;
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {done, error, fwd_valid}, 0);
      chk("rst_leds", leds_applied, 0);
      #20 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // LED happy path
      mark();
      pulse_led(3'b100);
      wait_tx(1, 8'hED, "led_cmd");
      chk("led_busy", busy, 1);
      send_rx(8'hFA);
      wait_tx(2, 8'h04, "led_arg");
      send_rx(8'hFA);
      wait_idle("led_idle");
      chk("led_done", done_cnt - d0, 1);
      chk("led_applied", leds_applied, 3'b100);
      chk("led_fwd", fwd_cnt - f0, 0);
      chk("led_busy_rise", busy_rise - b0, 1);

      // Resend on 0xFE
      mark();
      pulse_led(3'b011);
      wait_tx(1, 8'hED, "rs_cmd1");
      send_rx(8'hFE);
      wait_tx(2, 8'hED, "rs_cmd2");
      send_rx(8'hFA);
      wait_tx(3, 8'h03, "rs_arg");
      send_rx(8'hFA);
      wait_idle("rs_idle");
      chk("rs_done", done_cnt - d0, 1);
      chk("rs_error", error, 0);
      chk("rs_applied", leds_applied, 3'b011);

      // Retry exhaustion by timeout
      mark();
      pulse_led(3'b111);
      wait_idle("rx_idle");
      chk("rx_txcnt", tx_log.size() - t0, 4);
      for (int i = 0; i < 4; i++) chk("rx_txbyte", tx_log[t0 + i], 8'hED);
      chk("rx_error", error, 1);
      chk("rx_done", done_cnt - d0, 0);
      chk("rx_applied", leds_applied, 3'b011);

      // Reset with good BAT
      mark();
      pulse_rst();
      wait_tx(1, 8'hFF, "bat_ff");
      chk("bat_err_clr", error, 0);
      send_rx(8'hFA);
      send_rx(8'hAA);
      wait_idle("bat_idle");
      chk("bat_done", done_cnt - d0, 1);
      chk("bat_applied", leds_applied, 0);
      chk("bat_txcnt", tx_log.size() - t0, 1);
      chk("bat_fwd", fwd_cnt - f0, 0);

      // Reset with failed BAT
      mark();
      pulse_rst();
      wait_tx(1, 8'hFF, "bf_ff");
      send_rx(8'hFA);
      send_rx(8'hFC);
      wait_idle("bf_idle");
      chk("bf_error", error, 1);
      chk("bf_done", done_cnt - d0, 0);

      // Pass-through during command and in idle
      mark();
      send_rx(8'h5A);
      chk("pt_idle_fwd", {fwd_valid, fwd_byte}, {1'b1, 8'h5A});
      pulse_led(3'b010);
      wait_tx(1, 8'hED, "pt_cmd");
      send_rx(8'h1C);
      chk("pt_fwd", {fwd_valid, fwd_byte}, {1'b1, 8'h1C});
      @(posedge clk); #1;
      chk("pt_fwd_drop", fwd_valid, 0);
      send_rx(8'hFA);
      wait_tx(2, 8'h02, "pt_arg");
      send_rx(8'hFA);
      wait_idle("pt_idle");
      chk("pt_fwdcnt", fwd_cnt - f0, 2);
      chk("pt_applied", leds_applied, 3'b010);

      // Reset has priority over a simultaneous LED request
      mark();
      @(posedge clk); #1 kbd_reset_req = 1'b1; led_update = 1'b1; led_state = 3'b101;
      @(posedge clk); #1 kbd_reset_req = 1'b0; led_update = 1'b0;
      wait_tx(1, 8'hFF, "pr_first");
      send_rx(8'hFA);
      send_rx(8'hAA);
      wait_tx(2, 8'hED, "pr_second");
      tx_ready = 1'b0;
      send_rx(8'hFA);
      pulse_led(3'b001);
      pulse_rst();
      chk("pr_arg_held", {tx_valid, tx_data}, {1'b1, 8'h05});

      // Async reset mid SEND_ARG
      #3 rst_n = 1'b0;
      #1;
      chk("ar_tx", {tx_valid, tx_data}, 0);
      chk("ar_busy", busy, 0);
      chk("ar_flags", {done, error, fwd_valid, leds_applied}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; tx_ready = 1'b1;
      mark();
      repeat (10) @(negedge clk);
      chk("ar_no_pend", {busy_rise - b0, tx_log.size() - t0}, 0);
      chk("fwd_no_double", fwd_dbl, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
